keypoint_collect: RTL and testbench
===================================

KEYPOINT_COLLECT -- requirements
Module: keypoint_collect

Interface
REQ-001 Parameter IMG_W, default 640, pixels per DoG row.
REQ-002 Parameter IMG_H, default 480, rows per frame.
REQ-003 Parameter BORDER, default 1, pixel margin in which candidates are rejected.
REQ-004 Parameter DEPTH, default 16, keypoint FIFO entries, power of two.
REQ-005 clk  in  1  clock; all state SHALL update on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 frame_start  in  1  one-cycle pulse marking the first pixel of a frame.
REQ-008 in_valid  in  1  extremum-detector output qualifier, one pixel per asserted cycle.
REQ-009 is_ext  in  1  pixel is a 3x3x3 local extremum.
REQ-010 center  in  8  signed DoG value of the centre pixel.
REQ-011 thresh  in  7  unsigned contrast threshold.
REQ-012 kp_valid  out  1  FIFO head holds a record.
REQ-013 kp_ready  in  1  consumer accepts the head record.
REQ-014 kp_x  out  10  head record column; kp_y  out  9  head record row; kp_val  out  8  signed head record value.
REQ-015 kp_count  out  16  keypoints accepted this frame.
REQ-016 overflow  out  1  sticky flag: a qualified keypoint was dropped.
REQ-017 frame_done  out  1  one-cycle pulse after the last pixel of a frame.

Function
REQ-018 Coordinate counters x, y SHALL advance only on in_valid cycles; x SHALL wrap IMG_W-1 -> 0 and increment y; y SHALL wrap IMG_H-1 -> 0.
REQ-019 frame_start SHALL force the current pixel to (0,0), so counters hold (1,0) after that edge if in_valid is high and (0,0) if it is low; SHALL clear kp_count and overflow in the same edge; SHALL NOT flush the FIFO.
REQ-020 Qualification: in_valid && is_ext && BORDER<=x<=IMG_W-1-BORDER && BORDER<=y<=IMG_H-1-BORDER && |center| > thresh (strict).
REQ-021 |center| SHALL be computed as 8-bit unsigned, so center = -128 gives 128.
REQ-022 A qualified pixel SHALL be written as {x,y,center} at the sampling edge; kp_valid SHALL rise in the next cycle when the FIFO was empty (latency 1).
REQ-023 FIFO SHALL be first-word-fall-through; kp_x/kp_y/kp_val SHALL show the head entry while kp_valid=1; pop when kp_valid && kp_ready.
REQ-024 Full, pop in the same cycle: the write SHALL succeed and occupancy stays DEPTH.
REQ-025 Full, no pop: the record SHALL be dropped, overflow set to 1, and kp_count not incremented.
REQ-026 Empty: kp_ready SHALL be ignored; a simultaneous write SHALL NOT be popped in the same cycle.
REQ-027 kp_count SHALL increment per record written and saturate at 65535.
REQ-028 frame_done SHALL be 1 in exactly the cycle after the edge sampling in_valid at (IMG_W-1, IMG_H-1).
REQ-029 Head outputs SHALL be stable while kp_valid && !kp_ready.

Reset
REQ-030 While rst=0: x=0, y=0, FIFO empty, kp_valid=0, kp_x=0, kp_y=0, kp_val=0, kp_count=0, overflow=0, frame_done=0.
REQ-031 Reset mid-frame SHALL discard all FIFO contents; the first edge after release SHALL behave as pixel (0,0) if in_valid=1.

Verification (IMG_W=8, IMG_H=4, BORDER=1, DEPTH=4)
REQ-032 frame_start plus 32 valid pixels, is_ext=1 only at (3,2), center=-20, thresh=10 -> one record (3,2,-20), kp_valid rises 1 cycle later, kp_count=1, frame_done pulse after pixel 31.
REQ-033 is_ext=1 at (0,1), (7,2), (3,0), and (4,3) with |center|=50 -> no records, kp_count=0.
REQ-034 center=10 with thresh=10, then center=11, center=-128 (thresh=127) -> only the 11 and -128 records are accepted.
REQ-035 kp_ready=0, 6 qualified pixels -> 4 records held, overflow=1, kp_count=4; the next frame_start clears overflow and kp_count while the 4 records remain.
REQ-036 FIFO full, qualified pixel with kp_ready=1 in the same cycle -> head popped, new record appended, overflow stays 0.
REQ-037 rst pulsed low mid-frame with 2 records queued -> kp_valid=0 immediately; counters restart at (0,0).

Source files
------------

// File: rtl/keypoint_collect.sv
// Keypoint collector: tracks pixel coordinates, qualifies extrema against
// border and contrast limits, and queues {x, y, value} records in a
// first-word-fall-through FIFO with per-frame count and sticky overflow.
module keypoint_collect #(
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480,
   parameter int BORDER = 1,
   parameter int DEPTH  = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_start,
   input  logic               in_valid,
   input  logic               is_ext,
   input  logic signed [7:0]  center,
   input  logic [6:0]         thresh,
   output logic               kp_valid,
   input  logic               kp_ready,
   output logic [9:0]         kp_x,
   output logic [8:0]         kp_y,
   output logic signed [7:0]  kp_val,
   output logic [15:0]        kp_count,
   output logic               overflow,
   output logic               frame_done
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [9:0] X_LAST = 10'(IMG_W - 1);
   localparam logic [8:0] Y_LAST = 9'(IMG_H - 1);
   localparam logic [9:0] X_MIN  = 10'(BORDER);
   localparam logic [9:0] X_MAX  = 10'(IMG_W - 1 - BORDER);
   localparam logic [8:0] Y_MIN  = 9'(BORDER);
   localparam logic [8:0] Y_MAX  = 9'(IMG_H - 1 - BORDER);

   // Magnitude as 8-bit unsigned so that -128 maps to 128 rather than wrapping.
   function automatic logic [7:0] abs8(input logic signed [7:0] v);
      logic [7:0] neg;
      neg = ~v + 8'd1;
      return v[7] ? neg : v;
   endfunction

   logic [9:0]    x_q, x_d, cur_x;
   logic [8:0]    y_q, y_d, cur_y;
   logic [AW:0]   wr_ptr_q, rd_ptr_q;
   logic [15:0]   kp_count_q, kp_count_d;
   logic          overflow_q, overflow_d;
   logic          frame_done_q;
   logic [26:0]   mem_q [DEPTH];
   logic [26:0]   head;
   logic          in_border, qual, empty, full, pop, push, drop;

   // frame_start redefines the pixel being presented as (0,0).
   assign cur_x = frame_start ? 10'd0 : x_q;
   assign cur_y = frame_start ? 9'd0  : y_q;

   assign in_border = (cur_x >= X_MIN) && (cur_x <= X_MAX) &&
                      (cur_y >= Y_MIN) && (cur_y <= Y_MAX);
   assign qual  = in_valid && is_ext && in_border && (abs8(center) > {1'b0, thresh});

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   // Pop only a record already at the head; an empty FIFO ignores kp_ready.
   assign pop   = !empty && kp_ready;
   assign push  = qual && (!full || pop);
   assign drop  = qual && full && !pop;

   // Next coordinates, counters and sticky flag.
   always_comb begin
      x_d        = x_q;
      y_d        = y_q;
      kp_count_d = kp_count_q;
      overflow_d = overflow_q;
      if (in_valid) begin
         if (cur_x == X_LAST) begin
            x_d = 10'd0;
            y_d = (cur_y == Y_LAST) ? 9'd0 : cur_y + 9'd1;
         end else begin
            x_d = cur_x + 10'd1;
            y_d = cur_y;
         end
      end else if (frame_start) begin
         x_d = 10'd0;
         y_d = 9'd0;
      end
      if (frame_start) begin
         kp_count_d = 16'd0;
         overflow_d = 1'b0;
      end
      if (push && kp_count_d != 16'hFFFF) kp_count_d = kp_count_d + 16'd1;
      if (drop) overflow_d = 1'b1;
   end

   // Control state with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_q          <= '0;
         y_q          <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         kp_count_q   <= '0;
         overflow_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         x_q          <= x_d;
         y_q          <= y_d;
         kp_count_q   <= kp_count_d;
         overflow_q   <= overflow_d;
         frame_done_q <= in_valid && (cur_x == X_LAST) && (cur_y == Y_LAST);
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Record storage; contents are only observable through a valid head.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= {cur_x, cur_y, center};
   end

   assign head       = mem_q[rd_ptr_q[AW-1:0]];
   assign kp_valid   = !empty;
   assign kp_x       = kp_valid ? head[26:17] : 10'd0;
   assign kp_y       = kp_valid ? head[16:8]  : 9'd0;
   assign kp_val     = kp_valid ? head[7:0]   : 8'sd0;
   assign kp_count   = kp_count_q;
   assign overflow   = overflow_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_keypoint_collect.sv
// Directed bench for keypoint_collect on an 8x4 image, border 1, FIFO depth 4.
module tb_keypoint_collect;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        frame_start = 1'b0, in_valid = 1'b0, is_ext = 1'b0, kp_ready = 1'b0;
   logic [7:0]  center = 8'd0;
   logic [6:0]  thresh = 7'd10;
   logic        kp_valid, overflow, frame_done;
   logic [9:0]  kp_x;
   logic [8:0]  kp_y;
   logic [7:0]  kp_val;
   logic [15:0] kp_count;

   int tests = 0;
   int fails = 0;

   bit         ext_a [32];
   bit         rdy_a [32];
   logic [7:0] cen_a [32];
   logic [6:0] thr_a [32];

   keypoint_collect #(.IMG_W(8), .IMG_H(4), .BORDER(1), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .frame_start(frame_start), .in_valid(in_valid),
      .is_ext(is_ext), .center(center), .thresh(thresh), .kp_valid(kp_valid),
      .kp_ready(kp_ready), .kp_x(kp_x), .kp_y(kp_y), .kp_val(kp_val),
      .kp_count(kp_count), .overflow(overflow), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_head(input string tag, input logic [9:0] x, input logic [8:0] y,
                           input logic [7:0] v);
      chk({tag, "_valid"}, {31'd0, kp_valid}, 32'd1);
      chk({tag, "_xyv"}, {5'd0, kp_x, kp_y, kp_val}, {5'd0, x, y, v});
   endtask

   task automatic clr();
      for (int i = 0; i < 32; i++) begin
         ext_a[i] = 1'b0; rdy_a[i] = 1'b0; cen_a[i] = 8'd0; thr_a[i] = 7'd10;
      end
   endtask

   task automatic idle();
      frame_start = 1'b0; in_valid = 1'b0; is_ext = 1'b0; kp_ready = 1'b0;
   endtask

   // Drive pixels first..first+n-1 from the tables, frame_start on the first if fs.
   task automatic run_pixels(input int first, input int n, input bit fs);
      for (int i = first; i < first + n; i++) begin
         frame_start = fs && (i == first);
         in_valid    = 1'b1;
         is_ext      = ext_a[i];
         center      = cen_a[i];
         thresh      = thr_a[i];
         kp_ready    = rdy_a[i];
         @(posedge clk); #1;
      end
      idle();
   endtask

   task automatic pop_one();
      kp_ready = 1'b1;
      @(posedge clk); #1;
      kp_ready = 1'b0;
   endtask

   initial begin
      clr();
      #2;
      chk("rst_valid", {31'd0, kp_valid}, 32'd0);
      chk("rst_xyv", {5'd0, kp_x, kp_y, kp_val}, 32'd0);
      chk("rst_count", {16'd0, kp_count}, 32'd0);
      chk("rst_ovf_fd", {30'd0, overflow, frame_done}, 32'd0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;

      // Single extremum at (3,2).
      clr();
      for (int i = 0; i < 32; i++) cen_a[i] = 8'hEC;
      ext_a[19] = 1'b1;
      run_pixels(0, 19, 1'b1);
      chk("a_pre_valid", {31'd0, kp_valid}, 32'd0);
      run_pixels(19, 1, 1'b0);
      chk_head("a_rec", 10'd3, 9'd2, 8'hEC);
      chk("a_count", {16'd0, kp_count}, 32'd1);
      run_pixels(20, 11, 1'b0);
      chk("a_fd_early", {31'd0, frame_done}, 32'd0);
      run_pixels(31, 1, 1'b0);
      chk("a_fd_pulse", {31'd0, frame_done}, 32'd1);
      @(posedge clk); #1;
      chk("a_fd_end", {31'd0, frame_done}, 32'd0);
      pop_one();
      chk("a_popped", {31'd0, kp_valid}, 32'd0);
      pop_one();
      chk("a_empty_ready", {31'd0, kp_valid}, 32'd0);

      // Extrema only on or outside the border.
      clr();
      for (int i = 0; i < 32; i++) cen_a[i] = 8'd50;
      ext_a[8] = 1'b1; ext_a[23] = 1'b1; ext_a[3] = 1'b1; ext_a[28] = 1'b1;
      run_pixels(0, 32, 1'b1);
      chk("b_valid", {31'd0, kp_valid}, 32'd0);
      chk("b_count", {16'd0, kp_count}, 32'd0);

      // Threshold is strict; -128 has magnitude 128.
      clr();
      ext_a[9]  = 1'b1; cen_a[9]  = 8'd10;
      ext_a[10] = 1'b1; cen_a[10] = 8'd11;
      ext_a[11] = 1'b1; cen_a[11] = 8'h80; thr_a[11] = 7'd127;
      run_pixels(0, 32, 1'b1);
      chk("c_count", {16'd0, kp_count}, 32'd2);
      chk_head("c_rec0", 10'd2, 9'd1, 8'd11);
      pop_one();
      chk_head("c_rec1", 10'd3, 9'd1, 8'h80);
      pop_one();
      chk("c_empty", {31'd0, kp_valid}, 32'd0);

      // Six qualified pixels into a depth-4 FIFO with no consumer.
      clr();
      for (int k = 1; k <= 6; k++) begin
         ext_a[8 + k] = 1'b1; cen_a[8 + k] = 8'(30 + k);
      end
      run_pixels(0, 12, 1'b1);
      chk("d_ovf_before", {31'd0, overflow}, 32'd0);
      run_pixels(12, 20, 1'b0);
      chk("d_count", {16'd0, kp_count}, 32'd4);
      chk("d_ovf", {31'd0, overflow}, 32'd1);
      chk_head("d_head", 10'd1, 9'd1, 8'd31);
      frame_start = 1'b1;
      @(posedge clk); #1;
      frame_start = 1'b0;
      chk("d_fs_count", {16'd0, kp_count}, 32'd0);
      chk("d_fs_ovf", {31'd0, overflow}, 32'd0);
      chk_head("d_fs_head", 10'd1, 9'd1, 8'd31);

      // Full FIFO, write and pop in the same cycle.
      clr();
      ext_a[9] = 1'b1; cen_a[9] = 8'd99; rdy_a[9] = 1'b1;
      run_pixels(0, 10, 1'b1);
      chk("e_ovf", {31'd0, overflow}, 32'd0);
      chk("e_count", {16'd0, kp_count}, 32'd1);
      chk_head("e_h0", 10'd2, 9'd1, 8'd32);
      pop_one();
      chk_head("e_h1", 10'd3, 9'd1, 8'd33);
      pop_one();
      chk_head("e_h2", 10'd4, 9'd1, 8'd34);
      pop_one();
      chk_head("e_h3", 10'd1, 9'd1, 8'd99);
      pop_one();
      chk("e_empty", {31'd0, kp_valid}, 32'd0);

      // Mid-frame reset with two records queued.
      clr();
      ext_a[10] = 1'b1; cen_a[10] = 8'd40;
      ext_a[11] = 1'b1; cen_a[11] = 8'd41;
      run_pixels(10, 2, 1'b0);
      chk_head("f_queued", 10'd2, 9'd1, 8'd40);
      rst = 1'b0;
      #1;
      chk("f_rst_valid", {31'd0, kp_valid}, 32'd0);
      chk("f_rst_xyv", {5'd0, kp_x, kp_y, kp_val}, 32'd0);
      chk("f_rst_count", {16'd0, kp_count}, 32'd0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("f_after_valid", {31'd0, kp_valid}, 32'd0);
      clr();
      ext_a[9] = 1'b1; cen_a[9] = 8'd77;
      run_pixels(0, 10, 1'b0);
      chk_head("f_restart", 10'd1, 9'd1, 8'd77);
      chk("f_count", {16'd0, kp_count}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
